// File: rtl/burst_meter_pkg.sv
// Shared constants for burst_meter: FSM state encoding and default widths.
package burst_meter_pkg;

  localparam int STATE_W    = 1;
  localparam int LEN_W_DEF  = 8;
  localparam int DROP_W_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage

// File: rtl/burst_meter_sat_counter.sv
// Saturating up-counter with a sticky overflow bit that is set when an
// increment is requested while the count already sits at its maximum.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] ONE = W'(1);

  // Count register: clear, load to one, or saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (load1) begin
      cnt <= ONE;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == {W{1'b1}}) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + ONE;
      end
    end else begin
      cnt <= cnt;
      sat <= sat;
    end
  end

endmodule

// File: rtl/burst_meter.sv
// Measures burst lengths from an upstream run/fin tracker and presents them
// through a one-entry valid/ready register. Optional max_len tracking is
// enabled with BURST_METER_MAXTRACK_EN.
module burst_meter
  import burst_meter_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              fin,
  input  logic              len_ready,
  output logic              len_valid,
  output logic [LEN_W-1:0]  len_data,
  output logic              len_ovf,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              proto_err,
`ifdef BURST_METER_MAXTRACK_EN
  output logic [LEN_W-1:0]  max_len,
`endif
  output logic              busy
);

  state_e             r_state;
  logic               r_len_valid;
  logic [LEN_W-1:0]   r_len_data;
  logic               r_len_ovf;
  logic               r_proto_err;
  logic [LEN_W-1:0]   w_cnt;
  logic               w_sat;
  logic [DROP_W-1:0]  w_drop_cnt;
  logic               w_drop_sat;
  logic               w_load;
  logic               w_inc;
  logic               w_complete;
  logic               w_out_load;
  logic               w_drop_inc;

  assign w_load     = (r_state == IDLE) & run;
  assign w_inc      = (r_state == COUNT) & run & ~fin;
  assign w_complete = (r_state == COUNT) & fin;
  // A full register that is being drained this cycle can still take the new result.
  assign w_out_load = w_complete & (~r_len_valid | len_ready);
  assign w_drop_inc = w_complete & r_len_valid & ~len_ready & ~w_drop_sat;

  sat_counter #(.W(LEN_W)) u_len_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .load1 (w_load),
    .inc   (w_inc),
    .cnt   (w_cnt),
    .sat   (w_sat)
  );

  sat_counter #(.W(DROP_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .load1 (1'b0),
    .inc   (w_drop_inc),
    .cnt   (w_drop_cnt),
    .sat   (w_drop_sat)
  );

  // Burst FSM and sticky protocol-violation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (fin) begin
            r_proto_err <= 1'b1;
          end else begin
            r_proto_err <= r_proto_err;
          end
          if (run) begin
            r_state <= COUNT;
          end else begin
            r_state <= IDLE;
          end
        end
        COUNT: begin
          if (fin) begin
            r_state <= IDLE;
            if (run) begin
              r_proto_err <= 1'b1;
            end else begin
              r_proto_err <= r_proto_err;
            end
          end else if (!run) begin
            r_state     <= COUNT;
            r_proto_err <= 1'b1;
          end else begin
            r_state     <= COUNT;
            r_proto_err <= r_proto_err;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_proto_err <= 1'b1;
        end
      endcase
    end
  end

  // One-entry output register with valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_valid <= 1'b0;
      r_len_data  <= '0;
      r_len_ovf   <= 1'b0;
    end else if (w_out_load) begin
      r_len_valid <= 1'b1;
      r_len_data  <= w_cnt;
      r_len_ovf   <= w_sat;
    end else if (r_len_valid && len_ready) begin
      r_len_valid <= 1'b0;
    end else begin
      r_len_valid <= r_len_valid;
    end
  end

`ifdef BURST_METER_MAXTRACK_EN
  logic [LEN_W-1:0] r_max_len;
  logic [LEN_W-1:0] w_cand;

  assign w_cand = w_sat ? {LEN_W{1'b1}} : w_cnt;

  // Running maximum over every completed burst, dropped ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_len <= '0;
    end else if (w_complete && (w_cand > r_max_len)) begin
      r_max_len <= w_cand;
    end else begin
      r_max_len <= r_max_len;
    end
  end

  assign max_len = r_max_len;
`endif

  assign len_valid = r_len_valid;
  assign len_data  = r_len_data;
  assign len_ovf   = r_len_ovf;
  assign drop_cnt  = w_drop_cnt;
  assign proto_err = r_proto_err;
  assign busy      = (r_state == COUNT);

endmodule

// File: tb/tb_burst_meter.sv
// Self-checking bench: two burst_meter instances (LEN_W=8 and LEN_W=4) share
// stimulus and are compared every cycle against a behavioural model.
module tb_burst_meter;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic fin;
  logic len_ready;

  logic       v0, ovf0, perr0, busy0;
  logic [7:0] data0;
  logic [3:0] drop0;
  logic       v1, ovf1, perr1, busy1;
  logic [3:0] data1;
  logic [3:0] drop1;
`ifdef BURST_METER_MAXTRACK_EN
  logic [7:0] max0;
  logic [3:0] max1;
`endif

  int tests = 0;
  int fails = 0;

  int maxv [2] = '{255, 15};
  int m_busy [2];
  int m_k    [2];
  int m_valid[2];
  int m_data [2];
  int m_ovf  [2];
  int m_drop [2];
  int m_perr [2];
  int m_max  [2];

  always #5 clk = ~clk;

  burst_meter #(.LEN_W(8), .DROP_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .fin(fin), .len_ready(len_ready),
    .len_valid(v0), .len_data(data0), .len_ovf(ovf0), .drop_cnt(drop0),
    .proto_err(perr0),
`ifdef BURST_METER_MAXTRACK_EN
    .max_len(max0),
`endif
    .busy(busy0)
  );

  burst_meter #(.LEN_W(4), .DROP_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .fin(fin), .len_ready(len_ready),
    .len_valid(v1), .len_data(data1), .len_ovf(ovf1), .drop_cnt(drop1),
    .proto_err(perr1),
`ifdef BURST_METER_MAXTRACK_EN
    .max_len(max1),
`endif
    .busy(busy1)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_k[d] = 0; m_valid[d] = 0; m_data[d] = 0;
      m_ovf[d] = 0; m_drop[d] = 0; m_perr[d] = 0; m_max[d] = 0;
    end
  endtask

  // Burst length is an unbounded integer; the reported value clips at 2^W-1.
  task automatic model_update();
    int res;
    int ovf;
    for (int d = 0; d < 2; d++) begin
      res = (m_k[d] > maxv[d]) ? maxv[d] : m_k[d];
      ovf = (m_k[d] > maxv[d]) ? 1 : 0;
      if (m_busy[d] != 0 && fin) begin
        if (m_valid[d] == 0 || len_ready) begin
          m_valid[d] = 1; m_data[d] = res; m_ovf[d] = ovf;
        end else if (m_drop[d] < 15) begin
          m_drop[d] = m_drop[d] + 1;
        end
        if (res > m_max[d]) m_max[d] = res;
      end else if (m_valid[d] != 0 && len_ready) begin
        m_valid[d] = 0;
      end
      if (m_busy[d] == 0) begin
        if (fin) m_perr[d] = 1;
        if (run) begin
          m_busy[d] = 1; m_k[d] = 1;
        end
      end else if (fin) begin
        m_busy[d] = 0;
        if (run) m_perr[d] = 1;
      end else if (run) begin
        m_k[d] = m_k[d] + 1;
      end else begin
        m_perr[d] = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("valid0", int'(v0), m_valid[0]);
    chk("data0",  int'(data0), m_data[0]);
    chk("ovf0",   int'(ovf0), m_ovf[0]);
    chk("drop0",  int'(drop0), m_drop[0]);
    chk("perr0",  int'(perr0), m_perr[0]);
    chk("busy0",  int'(busy0), m_busy[0]);
    chk("valid1", int'(v1), m_valid[1]);
    chk("data1",  int'(data1), m_data[1]);
    chk("ovf1",   int'(ovf1), m_ovf[1]);
    chk("drop1",  int'(drop1), m_drop[1]);
    chk("perr1",  int'(perr1), m_perr[1]);
    chk("busy1",  int'(busy1), m_busy[1]);
`ifdef BURST_METER_MAXTRACK_EN
    chk("max0", int'(max0), m_max[0]);
    chk("max1", int'(max1), m_max[1]);
`endif
  endtask

  // One clock: model sees the inputs the DUT samples, outputs compared at negedge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic burst(input int k);
    run = 1'b1; fin = 1'b0;
    repeat (k) step();
    run = 1'b0; fin = 1'b1;
    step();
    fin = 1'b0;
  endtask

  initial begin
    int gap;
    int k;
    model_reset();
    rst_n = 1'b0; run = 1'b0; fin = 1'b0; len_ready = 1'b0;
    @(negedge clk);
    step(); step();
    chk("rst_valid", int'(v0), 0);
    chk("rst_data",  int'(data0), 0);
    chk("rst_busy",  int'(busy0), 0);
    rst_n = 1'b1;

    len_ready = 1'b1;
    burst(5);
    chk("b5_valid", int'(v0), 1);
    chk("b5_data",  int'(data0), 5);
    chk("b5_ovf",   int'(ovf0), 0);
    step();
    chk("b5_valid_clr", int'(v0), 0);

    burst(20);
    chk("sat_data1", int'(data1), 15);
    chk("sat_ovf1",  int'(ovf1), 1);
    chk("sat_data0", int'(data0), 20);
    step();

    len_ready = 1'b0;
    burst(3); step();
    burst(4); step();
    burst(6);
    chk("bp_data",  int'(data0), 3);
    chk("bp_drop",  int'(drop0), 2);
    chk("bp_valid", int'(v0), 1);
    len_ready = 1'b1;
    step();
    chk("bp_drain", int'(v0), 0);
    len_ready = 1'b0;

    burst(2); step();
    chk("co_old", int'(data0), 2);
    run = 1'b1;
    repeat (7) step();
    run = 1'b0; fin = 1'b1; len_ready = 1'b1;
    step();
    chk("co_data",  int'(data0), 7);
    chk("co_valid", int'(v0), 1);
    chk("co_drop",  int'(drop0), 2);
    fin = 1'b0;
    step();
    len_ready = 1'b0;

    chk("pe_clean", int'(perr0), 0);
    fin = 1'b1; step(); fin = 1'b0; step();
    chk("pe_idle_fin", int'(perr0), 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("pe_rst", int'(perr0), 0);
    len_ready = 1'b1;
    run = 1'b1; step(); step();
    fin = 1'b1; step();
    chk("pe_runfin", int'(perr0), 1);
    chk("pe_runfin_data", int'(data0), 2);
    run = 1'b0; fin = 1'b0; step(); step();
    chk("pe_sticky", int'(perr0), 1);

    rst_n = 1'b0; step(); rst_n = 1'b1;
    run = 1'b1; repeat (3) step();
    rst_n = 1'b0; step();
    chk("mr_valid", int'(v0), 0);
    chk("mr_data",  int'(data0), 0);
    chk("mr_busy",  int'(busy0), 0);
    chk("mr_drop",  int'(drop0), 0);
    chk("mr_perr",  int'(perr0), 0);
    rst_n = 1'b1;
    step(); step();
    run = 1'b0; fin = 1'b1;
    step();
    chk("mr_len", int'(data0), 2);
    chk("mr_len_valid", int'(v0), 1);
    fin = 1'b0;
    step();

    for (int b = 0; b < 250; b++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        run = 1'b0;
        fin = ($urandom_range(0, 19) == 0);
        len_ready = $urandom_range(0, 1);
        step();
      end
      k = $urandom_range(1, 20);
      for (int j = 0; j < k; j++) begin
        run = ($urandom_range(0, 15) != 0);
        fin = 1'b0;
        len_ready = $urandom_range(0, 1);
        step();
      end
      fin = 1'b1;
      run = ($urandom_range(0, 9) == 0);
      len_ready = $urandom_range(0, 1);
      step();
      fin = 1'b0; run = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
